// File: rtl/i2s_tx_fifo.sv
// i2s_tx_fifo: I2S / left-justified / right-justified stereo DAC transmitter
// with a sample FIFO in front of it.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   s_valid/s_ready   sample push handshake (s_ready = FIFO not full)
//   s_left, s_right   signed stereo sample pushed as one FIFO entry
//   mute              transmit zeros while the FIFO keeps draining
//   underrun_clr      clears the sticky underrun flag
//   underrun          sticky: a frame started with the FIFO empty
//   fifo_level        number of stereo samples held
//   din, bck, lrck    DAC serial data, bit clock and word clock
module i2s_tx_fifo #(
  parameter int FMT     = 0,
  parameter int DATA_W  = 16,
  parameter int SLOT_W  = 32,
  parameter int CLK_HZ  = 25000000,
  parameter int LRCK_HZ = 48000,
  parameter int FIFO_AW = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DATA_W-1:0]   s_left,
  input  logic [DATA_W-1:0]   s_right,
  input  logic                mute,
  input  logic                underrun_clr,
  output logic                underrun,
  output logic [FIFO_AW:0]    fifo_level,
  output logic                din,
  output logic                bck,
  output logic                lrck
);

  localparam int CW = $clog2(4 * SLOT_W);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [FIFO_AW:0] LEVEL_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic LRCK_RST = (FMT == 0) ? 1'b0 : 1'b1;
  // Rounded phase increment: one tick per half bck period.
  localparam logic [63:0] PA_NUM = 64'(4 * SLOT_W) * 64'(LRCK_HZ);
  localparam logic [63:0] PA_INC64 = ((PA_NUM << 32) + 64'(CLK_HZ / 2)) / 64'(CLK_HZ);
  localparam logic [31:0] PA_INC = PA_INC64[31:0];

  generate
    if (PA_INC64 >= 64'h0000_0000_8000_0000) begin : g_rate_check
      $error("i2s_tx_fifo: bit clock too fast for CLK_HZ (PA_INC >= 2**31)");
    end
  endgenerate

  // Build one SLOT_W-bit channel word from a sample.
  function automatic logic [SLOT_W-1:0] fmt_slot(input logic [DATA_W-1:0] x);
    logic [SLOT_W-1:0] w;
    if (FMT == 2) begin
      w = {SLOT_W{x[DATA_W-1]}};
      w[DATA_W-1:0] = x;
    end else begin
      w = '0;
      w[SLOT_W-1 -: DATA_W] = x;
    end
    return w;
  endfunction

  logic [31:0]           pa_r;
  logic [CW-1:0]         cnt_r;
  logic [2*SLOT_W-1:0]   sreg_r;
  logic                  lrck_r;
  logic                  underrun_r;
  logic                  ready_r;
  logic [FIFO_AW-1:0]    wr_ptr_r;
  logic [FIFO_AW-1:0]    rd_ptr_r;
  logic [FIFO_AW:0]      level_r;
  logic [2*DATA_W-1:0]   mem_r [DEPTH];

  logic [32:0]           pa_sum_s;
  logic                  tick_s;
  logic [CW-1:0]         cnt_nxt_s;
  logic [CW-2:0]         b_nxt_s;
  logic [CW-2:0]         b_nxt_p1_s;
  logic                  frame_load_s;
  logic                  shift_s;
  logic                  empty_s;
  logic                  push_s;
  logic                  pop_s;
  logic [FIFO_AW:0]      level_nxt_s;
  logic [2*DATA_W-1:0]   rd_word_s;
  logic [2*SLOT_W-1:0]   frame_word_s;
  logic                  lrck_nxt_s;

  // Rate generator, bit-position decode and FIFO handshake terms.
  always_comb begin
    pa_sum_s     = {1'b0, pa_r} + {1'b0, PA_INC};
    tick_s       = pa_sum_s[32];
    cnt_nxt_s    = cnt_r + {{(CW-1){1'b0}}, 1'b1};
    b_nxt_s      = cnt_nxt_s[CW-1:1];
    b_nxt_p1_s   = b_nxt_s + {{(CW-2){1'b0}}, 1'b1};
    frame_load_s = tick_s && (cnt_r == CNT_MAX);
    // cnt odd -> even is a bck falling edge; the wrap edge loads instead.
    shift_s      = tick_s && cnt_r[0] && !frame_load_s;
    empty_s      = (level_r == '0);
    push_s       = s_valid && ready_r;
    pop_s        = frame_load_s && !empty_s;
    rd_word_s    = mem_r[rd_ptr_r];
  end

  // Next FIFO occupancy from push/pop.
  always_comb begin
    level_nxt_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + {{FIFO_AW{1'b0}}, 1'b1};
      2'b01:   level_nxt_s = level_r - {{FIFO_AW{1'b0}}, 1'b1};
      default: level_nxt_s = level_r;
    endcase
  end

  // Frame word for the next load; an empty FIFO or mute sends silence.
  always_comb begin
    if (mute || empty_s) begin
      frame_word_s = '0;
    end else begin
      frame_word_s = {fmt_slot(rd_word_s[2*DATA_W-1:DATA_W]),
                      fmt_slot(rd_word_s[DATA_W-1:0])};
    end
  end

  // Word clock for the bit period being entered. Slot boundaries are powers
  // of two, so the top bit of the bit index selects the channel.
  always_comb begin
    if (FMT == 0) begin
      lrck_nxt_s = b_nxt_p1_s[CW-2];
    end else begin
      lrck_nxt_s = ~b_nxt_s[CW-2];
    end
  end

  // Phase accumulator and half-bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pa_r   <= '0;
      cnt_r  <= '0;
      lrck_r <= LRCK_RST;
    end else begin
      pa_r <= pa_sum_s[31:0];
      if (tick_s) begin
        cnt_r  <= cnt_nxt_s;
        lrck_r <= lrck_nxt_s;
      end
    end
  end

  // Output shift register: frame load at wrap, shift on bck falling edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_r <= '0;
    end else if (frame_load_s) begin
      sreg_r <= frame_word_s;
    end else if (shift_s) begin
      sreg_r <= {sreg_r[2*SLOT_W-2:0], 1'b0};
    end
  end

  // FIFO pointers, occupancy, registered ready and sticky underrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      level_r    <= '0;
      ready_r    <= 1'b1;
      underrun_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(FIFO_AW-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(FIFO_AW-1){1'b0}}, 1'b1};
      end
      level_r <= level_nxt_s;
      ready_r <= (level_nxt_s != LEVEL_FULL);
      // Setting wins over a simultaneous clear.
      if (frame_load_s && empty_s) begin
        underrun_r <= 1'b1;
      end else if (underrun_clr) begin
        underrun_r <= 1'b0;
      end
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {s_left, s_right};
    end
  end

  assign s_ready    = ready_r;
  assign underrun   = underrun_r;
  assign fifo_level = level_r;
  assign din        = sreg_r[2*SLOT_W-1];
  assign bck        = cnt_r[0];
  assign lrck       = lrck_r;

endmodule

// File: doc/i2s_tx_fifo.md
Name: i2s_tx_fifo

Overview:
Parametrised I2S transmitter for external stereo DACs (PCM5102 class), the successor to the fixed 16-bit/32-bck-frame I2S output. It adds configurable sample width and slot width, three framing formats (I2S, left-justified, right-justified), and a sample FIFO with a valid/ready push interface. It also provides a mute control and a sticky underrun flag. It sits between the audio DMA/CPU sample source and the DAC pins, in the SoC clock domain.

Parameters:
FMT, 0, framing: 0 = I2S standard, 1 = left-justified, 2 = right-justified
DATA_W, 16, sample width in bits; legal range 8..SLOT_W
SLOT_W, 32, bck periods per channel slot; legal values 16 or 32
CLK_HZ, 25000000, input clock frequency in Hz
LRCK_HZ, 48000, output frame (sample) rate in Hz
FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW stereo samples

Ports:
clk  in  1  system clock, 25-100 MHz
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  sample push request
s_ready  out  1  FIFO can accept a sample (= not full)
s_left  in  DATA_W  left sample, signed two's complement
s_right  in  DATA_W  right sample, signed two's complement
mute  in  1  1 = transmit zeros (FIFO still drains)
underrun_clr  in  1  clears the underrun flag
underrun  out  1  sticky: a frame started with the FIFO empty
fifo_level  out  FIFO_AW+1  number of samples held
din  out  1  DAC serial data
bck  out  1  DAC bit clock
lrck  out  1  DAC word clock

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Rate generator:
  - 32-bit phase accumulator, PA_INC = round(2**32 * 4*SLOT_W*LRCK_HZ / CLK_HZ).
  - Elaboration error if PA_INC >= 2**31.
  - tick = carry out of pa + PA_INC, asserted for one clk.
- Half-bit counter: cnt, log2(4*SLOT_W) bits, increments on tick and wraps.
  - bck = cnt[0].
  - Bit period b = cnt[top:1], range 0..2*SLOT_W-1.
  - Left slot is b < SLOT_W.
- lrck:
  - FMT=0: lrck = 0 (left) when (b+1) mod 2*SLOT_W < SLOT_W. This moves lrck one bck ahead of the MSB.
  - FMT=1/2: lrck = 1 (left) when b < SLOT_W.
- Slot word formatting, SLOT_W bits per channel:
  - FMT=0/1: data left-aligned, LSBs zero-padded.
  - FMT=2: data right-aligned, sign-extended.
  - mute or underrun: both slots are zero.
- Shift register sreg (2*SLOT_W bits); din = sreg MSB.
  - Frame load: on the tick where cnt wraps max->0, sreg <= {left_slot, right_slot}.
  - On every other tick with cnt[0] going 1->0, sreg shifts left by 1 with 0 fill.
  - din therefore changes only on bck falling edges and is stable at each rising edge.
- FIFO pop: occurs on the frame-load cycle if fifo_level != 0.
  - If the FIFO is empty at frame load: load zeros and set underrun.
- FIFO push: on s_valid && s_ready.
  - s_ready = (fifo_level != 2**FIFO_AW), computed from the current level only. When full, a simultaneous pop does not allow a push in the same cycle.
  - Push and pop in the same cycle leave fifo_level unchanged. Read and write pointers wrap modulo depth.
  - Push into an empty FIFO on a frame-load cycle: that frame underruns; the pushed sample plays next frame.
- underrun: set has priority over underrun_clr in the same cycle.
- Reset values and mid-operation reset:
  - pa = 0, cnt = 0, sreg = 0, FIFO empty (fifo_level = 0), underrun = 0.
  - din = 0, bck = 0, s_ready = 1.
  - lrck = 0 for FMT=0, 1 for FMT=1/2.
  - Assertion mid-frame discards the FIFO contents and the frame in progress immediately. After release, output restarts at b=0.
- Latency: a sample pushed into an empty FIFO appears at the next frame load. Its MSB reaches din 0 bck periods (FMT=1), 1 bck period (FMT=0) or SLOT_W-DATA_W bck periods (FMT=2) after the left-slot lrck edge.

Test Plan:
- FMT=0, DATA_W=16, SLOT_W=16: push L=0x8001, R=0x7FFE.
  - Required: lrck falls; sampling din on bck rising edges gives 1 previous-frame bit, then 1000000000000001.
  - lrck rises one bck before R MSB; then 0111111111111110.
- FMT=1, DATA_W=24, SLOT_W=32: push L=0x123456.
  - Required: MSB on the first rising bck after lrck rises; 24 data bits then 8 zeros; lrck high for exactly 32 bck.
- FMT=2, DATA_W=16, SLOT_W=32: push L=0x8000.
  - Required: left slot is 16 ones then 1000000000000000.
  - Last bit coincides with the final bck before lrck falls.
- Underrun:
  - Empty FIFO through a frame load -> din all zeros, underrun=1.
  - Pulse underrun_clr -> underrun=0.
  - underrun_clr asserted on an underrunning frame-load cycle -> underrun remains 1.
- FIFO full, FIFO_AW=2, no frame load during the pushes:
  - Push 5 samples back-to-back -> s_ready=0 after 4, fifo_level=4, fifth not accepted.
  - Playback order is 1,2,3,4; mute=1 yields zeros while fifo_level still decrements per frame.
- Rate and reset:
  - CLK_HZ=25e6, LRCK_HZ=48000, SLOT_W=32, 1e6 clk cycles -> 1920 +/-1 lrck periods.
  - rst_n low mid-frame -> all outputs at reset values asynchronously, fifo_level=0.
